tx_envelope_seq: RTL and testbench

TX_ENVELOPE_SEQ -- requirements
Module: tx_envelope_seq

---
 rtl/tx_envelope_seq.sv | 218 +++++++++++++++++++++
 tb/tb_tx_envelope_seq.sv | 273 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/tx_envelope_seq.sv
// Transmit envelope sequencer: PTT sequencing, profile-shaped ramp up/down and
// envelope scaling of the I/Q stream (SSB) or generation of a CW carrier level.
module tx_envelope_seq #(
    parameter int IQ_WIDTH      = 16,
    parameter int PROFILE_WIDTH = 16,
    parameter int RAMP_BITS     = 9,
    parameter int STEP_DIV      = 300,
    parameter int SEQ_DELAY     = 1024,
    parameter int HANG_CYCLES   = 4096,
    parameter int MAX_CW_LEVEL  = 24000
) (
    input  logic                        clock,
    input  logic                        reset,
    input  logic                        cw_mode,
    input  logic                        cw_key,
    input  logic                        ptt_req,
    input  logic signed [IQ_WIDTH-1:0]  iq_in_real,
    input  logic signed [IQ_WIDTH-1:0]  iq_in_imag,
    input  logic                        iq_in_valid,
    output logic [RAMP_BITS-1:0]        prof_addr,
    input  logic [PROFILE_WIDTH-1:0]    prof_data,
    output logic signed [IQ_WIDTH-1:0]  iq_out_real,
    output logic signed [IQ_WIDTH-1:0]  iq_out_imag,
    output logic                        iq_out_valid,
    output logic                        ptt_out,
    output logic                        tx_active,
    output logic [2:0]                  state
);

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_SEQ       = 3'd1,
        ST_RAMP_UP   = 3'd2,
        ST_HOLD      = 3'd3,
        ST_RAMP_DOWN = 3'd4,
        ST_HANG      = 3'd5
    } state_t;

    localparam int TMR_MAX = (SEQ_DELAY > HANG_CYCLES) ? SEQ_DELAY : HANG_CYCLES;
    localparam int TMR_W   = $clog2(TMR_MAX + 1);
    localparam int DIV_W   = $clog2(STEP_DIV + 1);
    localparam int CW_W    = IQ_WIDTH + PROFILE_WIDTH;
    localparam int PROD_W  = CW_W + 1;

    localparam logic [RAMP_BITS-1:0] RAMP_MAX  = {RAMP_BITS{1'b1}};
    localparam logic [RAMP_BITS-1:0] RAMP_ONE  = RAMP_BITS'(1);
    localparam logic [TMR_W-1:0]     TMR_ONE   = TMR_W'(1);
    localparam logic [DIV_W-1:0]     DIV_ONE   = DIV_W'(1);
    localparam logic [TMR_W-1:0]     SEQ_LAST  = TMR_W'(SEQ_DELAY - 1);
    localparam logic [TMR_W-1:0]     HANG_LAST = TMR_W'(HANG_CYCLES - 1);
    localparam logic [DIV_W-1:0]     DIV_LAST  = DIV_W'(STEP_DIV - 1);

    state_t                     state_q, state_d;
    logic                       mode_q, mode_d;
    logic [TMR_W-1:0]           tmr_q, tmr_d;
    logic [DIV_W-1:0]           div_q, div_d;
    logic [RAMP_BITS-1:0]       ramp_q, ramp_d;
    logic [PROFILE_WIDTH-1:0]   env_q;
    logic                       ptt_q, act_q;
    logic                       s1_valid_q, out_valid_q;
    logic signed [IQ_WIDTH-1:0] s1_real_q, s1_imag_q, out_real_q, out_imag_q;
    logic signed [IQ_WIDTH-1:0] s1_real_d, s1_imag_d;

    logic                       key_s, in_ramp_s, tick_s, gate_open_s;
    logic signed [PROD_W-1:0]   env_signed_s, ssb_real_s, ssb_imag_s;
    logic [CW_W-1:0]            cw_prod_s;

    // While idle the live mode selects the key; afterwards the latched mode does.
    assign key_s       = ((state_q == ST_IDLE) ? cw_mode : mode_q) ? cw_key : ptt_req;
    assign in_ramp_s   = (state_q == ST_RAMP_UP) || (state_q == ST_RAMP_DOWN);
    assign tick_s      = in_ramp_s && (div_q == DIV_LAST);
    assign gate_open_s = in_ramp_s || (state_q == ST_HOLD);

    // Sequencer next state; a key change wins over a coincident step tick.
    always_comb begin
        state_d = state_q;
        mode_d  = mode_q;
        ramp_d  = ramp_q;
        case (state_q)
            ST_IDLE: begin
                if (key_s) begin
                    state_d = ST_SEQ;
                    mode_d  = cw_mode;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_SEQ: begin
                if (!key_s)                 state_d = ST_IDLE;
                else if (tmr_q == SEQ_LAST) state_d = ST_RAMP_UP;
                else                        state_d = ST_SEQ;
            end
            ST_RAMP_UP: begin
                if (!key_s)                 state_d = ST_RAMP_DOWN;
                else if (ramp_q == RAMP_MAX) state_d = ST_HOLD;
                else if (tick_s)            ramp_d  = ramp_q + RAMP_ONE;
                else                        ramp_d  = ramp_q;
            end
            ST_HOLD: begin
                if (!key_s) state_d = ST_RAMP_DOWN;
                else        state_d = ST_HOLD;
            end
            ST_RAMP_DOWN: begin
                if (key_s)                       state_d = ST_RAMP_UP;
                else if (ramp_q == '0)           state_d = mode_q ? ST_HANG : ST_IDLE;
                else if (tick_s)                 ramp_d  = ramp_q - RAMP_ONE;
                else                             ramp_d  = ramp_q;
            end
            ST_HANG: begin
                if (key_s)                   state_d = ST_RAMP_UP;
                else if (tmr_q == HANG_LAST) state_d = ST_IDLE;
                else                         state_d = ST_HANG;
            end
            default: begin
                state_d = ST_IDLE;
                ramp_d  = '0;
            end
        endcase
    end

    // Dwell timer (SEQ/HANG) and step divider (ramps), both cleared on any state change.
    always_comb begin
        tmr_d = '0;
        div_d = '0;
        if (state_d != state_q) begin
            tmr_d = '0;
            div_d = '0;
        end else if ((state_q == ST_SEQ) || (state_q == ST_HANG)) begin
            tmr_d = tmr_q + TMR_ONE;
        end else if (in_ramp_s && !tick_s) begin
            div_d = div_q + DIV_ONE;
        end else begin
            tmr_d = '0;
            div_d = '0;
        end
    end

    // Sequencer state, counters and the status flags derived from the next state.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= ST_IDLE;
            mode_q  <= 1'b0;
            tmr_q   <= '0;
            div_q   <= '0;
            ramp_q  <= '0;
            ptt_q   <= 1'b0;
            act_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            mode_q  <= mode_d;
            tmr_q   <= tmr_d;
            div_q   <= div_d;
            ramp_q  <= ramp_d;
            ptt_q   <= (state_d != ST_IDLE);
            act_q   <= (state_d == ST_RAMP_UP) || (state_d == ST_HOLD) ||
                       (state_d == ST_RAMP_DOWN);
        end
    end

    // Envelope register behind the external ROM's one-clock read.
    always_ff @(posedge clock) begin
        if (reset) env_q <= '0;
        else       env_q <= prof_data;
    end

    assign env_signed_s = PROD_W'($signed({1'b0, env_q}));
    assign ssb_real_s   = PROD_W'(iq_in_real) * env_signed_s;
    assign ssb_imag_s   = PROD_W'(iq_in_imag) * env_signed_s;
    assign cw_prod_s    = CW_W'(MAX_CW_LEVEL) * CW_W'(env_q);

    // First pipeline stage value: muted outside the ramp/hold window.
    always_comb begin
        s1_real_d = '0;
        s1_imag_d = '0;
        if (!gate_open_s) begin
            s1_real_d = '0;
            s1_imag_d = '0;
        end else if (mode_q) begin
            s1_real_d = $signed(IQ_WIDTH'(cw_prod_s >> PROFILE_WIDTH));
            s1_imag_d = '0;
        end else begin
            s1_real_d = IQ_WIDTH'(ssb_real_s >>> PROFILE_WIDTH);
            s1_imag_d = IQ_WIDTH'(ssb_imag_s >>> PROFILE_WIDTH);
        end
    end

    // Two-stage output pipeline; data only advances alongside a valid sample.
    always_ff @(posedge clock) begin
        if (reset) begin
            s1_valid_q  <= 1'b0;
            out_valid_q <= 1'b0;
            s1_real_q   <= '0;
            s1_imag_q   <= '0;
            out_real_q  <= '0;
            out_imag_q  <= '0;
        end else begin
            s1_valid_q  <= iq_in_valid;
            out_valid_q <= s1_valid_q;
            if (iq_in_valid) begin
                s1_real_q <= s1_real_d;
                s1_imag_q <= s1_imag_d;
            end
            if (s1_valid_q) begin
                out_real_q <= s1_real_q;
                out_imag_q <= s1_imag_q;
            end
        end
    end

    assign prof_addr    = ramp_q;
    assign iq_out_real  = out_real_q;
    assign iq_out_imag  = out_imag_q;
    assign iq_out_valid = out_valid_q;
    assign ptt_out      = ptt_q;
    assign tx_active    = act_q;
    assign state        = state_q;

endmodule

// File: tb/tb_tx_envelope_seq.sv
// Self-checking bench for tx_envelope_seq: directed vector table, ramp-reversal
// sequence and randomized traffic compared against a behavioural model.
module tb_tx_envelope_seq;

    localparam int IQW   = 16;
    localparam int PW    = 16;
    localparam int RB    = 3;
    localparam int SDIV  = 1;
    localparam int SDLY  = 4;
    localparam int HANG  = 10;
    localparam int CWMAX = 24000;
    localparam int RMAX  = (1 << RB) - 1;
    localparam int DC    = -99999;

    logic                   clock = 1'b0;
    logic                   reset = 1'b1;
    logic                   cw_mode = 1'b0, cw_key = 1'b0, ptt_req = 1'b0;
    logic signed [IQW-1:0]  iq_in_real = '0, iq_in_imag = '0;
    logic                   iq_in_valid = 1'b0;
    logic [RB-1:0]          prof_addr;
    logic [PW-1:0]          prof_data;
    logic signed [IQW-1:0]  iq_out_real, iq_out_imag;
    logic                   iq_out_valid, ptt_out, tx_active;
    logic [2:0]             state;

    int n_checks = 0;
    int n_fail   = 0;

    tx_envelope_seq #(
        .IQ_WIDTH(IQW), .PROFILE_WIDTH(PW), .RAMP_BITS(RB), .STEP_DIV(SDIV),
        .SEQ_DELAY(SDLY), .HANG_CYCLES(HANG), .MAX_CW_LEVEL(CWMAX)
    ) dut (
        .clock(clock), .reset(reset), .cw_mode(cw_mode), .cw_key(cw_key),
        .ptt_req(ptt_req), .iq_in_real(iq_in_real), .iq_in_imag(iq_in_imag),
        .iq_in_valid(iq_in_valid), .prof_addr(prof_addr), .prof_data(prof_data),
        .iq_out_real(iq_out_real), .iq_out_imag(iq_out_imag),
        .iq_out_valid(iq_out_valid), .ptt_out(ptt_out), .tx_active(tx_active),
        .state(state)
    );

    always #5 clock = ~clock;

    // Profile ROM: addr * 8192 with one clock of read latency.
    always_ff @(posedge clock) prof_data <= {prof_addr, 13'd0};

    // ---------------- behavioural reference model ----------------
    // phase numbers follow the published state codes: 0 idle .. 5 hang
    int m_phase = 0, m_mode = 0, m_cnt = 0, m_div = 0, m_ramp = 0;
    int m_rom = 0, m_env = 0;
    int m_s1_r = 0, m_s1_i = 0, m_o_r = 0, m_o_i = 0;
    bit m_s1_v = 0, m_o_v = 0;

    task automatic model_step();
        bit key, tick, open;
        int nxt;
        if (reset) begin
            m_rom = m_ramp * 8192;
            m_phase = 0; m_mode = 0; m_cnt = 0; m_div = 0; m_ramp = 0; m_env = 0;
            m_s1_r = 0; m_s1_i = 0; m_s1_v = 0; m_o_r = 0; m_o_i = 0; m_o_v = 0;
            return;
        end
        // two-deep sample delay line, values captured only with valid
        if (m_s1_v) begin
            m_o_r = m_s1_r;
            m_o_i = m_s1_i;
        end
        m_o_v = m_s1_v;
        open = (m_phase >= 2) && (m_phase <= 4);
        if (iq_in_valid) begin
            if (!open) begin
                m_s1_r = 0; m_s1_i = 0;
            end else if (m_mode != 0) begin
                m_s1_r = (CWMAX * m_env) / 65536; m_s1_i = 0;
            end else begin
                m_s1_r = int'((longint'(iq_in_real) * m_env) >>> 16);
                m_s1_i = int'((longint'(iq_in_imag) * m_env) >>> 16);
            end
        end
        m_s1_v = iq_in_valid;
        m_env = m_rom;
        m_rom = m_ramp * 8192;
        // envelope sequencing rules
        key = (((m_phase == 0) ? int'(cw_mode) : m_mode) != 0) ? cw_key : ptt_req;
        tick = 1'b0;
        if (m_phase == 2 || m_phase == 4) begin
            tick = (m_div % SDIV) == (SDIV - 1);
            m_div++;
        end
        nxt = m_phase;
        case (m_phase)
            0: if (key) begin nxt = 1; m_mode = int'(cw_mode); end
            1: begin
                m_cnt++;
                if (!key) nxt = 0;
                else if (m_cnt == SDLY) nxt = 2;
            end
            2: if (!key) nxt = 4; else if (m_ramp == RMAX) nxt = 3; else if (tick) m_ramp++;
            3: if (!key) nxt = 4;
            4: if (key) nxt = 2; else if (m_ramp == 0) nxt = (m_mode != 0) ? 5 : 0;
               else if (tick) m_ramp--;
            5: begin
                m_cnt++;
                if (key) nxt = 2;
                else if (m_cnt == HANG) nxt = 0;
            end
            default: nxt = 0;
        endcase
        if (nxt != m_phase) begin
            m_cnt = 0;
            m_div = 0;
        end
        m_phase = nxt;
    endtask

    task automatic chk(input string nm, input longint act, input longint exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got %0d, expected %0d", nm, $time, act, exp);
        end
    endtask

    task automatic check_model();
        chk("model.state", state, m_phase);
        chk("model.ptt", ptt_out, (m_phase != 0));
        chk("model.tx_active", tx_active, (m_phase >= 2 && m_phase <= 4));
        chk("model.prof_addr", prof_addr, m_ramp);
        chk("model.valid", iq_out_valid, m_o_v);
        chk("model.real", iq_out_real, m_o_r);
        chk("model.imag", iq_out_imag, m_o_i);
    endtask

    // one clock: inputs already stable, sample outputs on the falling edge
    task automatic cycle();
        @(posedge clock);
        model_step();
        @(negedge clock);
        check_model();
    endtask

    task automatic drive(input bit r, input bit m, input bit k, input bit p,
                         input bit v, input int ir, input int ii);
        reset = r; cw_mode = m; cw_key = k; ptt_req = p; iq_in_valid = v;
        iq_in_real = IQW'(ir);
        iq_in_imag = IQW'(ii);
    endtask

    // ---------------- directed vector table ----------------
    typedef struct {
        bit rst, mode, key, ptt;
        int ir, ii, n;
        int e_state, e_ptt, e_act, e_addr, e_vld, e_real, e_imag;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(bit rst, bit mode, bit key, bit ptt, int ir, int ii, int n,
                                int es, int ep, int ea, int ead, int ev, int er, int ei);
        vec_t v;
        v.rst = rst; v.mode = mode; v.key = key; v.ptt = ptt; v.ir = ir; v.ii = ii; v.n = n;
        v.e_state = es; v.e_ptt = ep; v.e_act = ea; v.e_addr = ead; v.e_vld = ev;
        v.e_real = er; v.e_imag = ei;
        return v;
    endfunction

    task automatic chk_row(input int r, input vec_t v);
        chk($sformatf("row%0d.state", r), state, v.e_state);
        chk($sformatf("row%0d.ptt", r), ptt_out, v.e_ptt);
        chk($sformatf("row%0d.tx_active", r), tx_active, v.e_act);
        chk($sformatf("row%0d.prof_addr", r), prof_addr, v.e_addr);
        chk($sformatf("row%0d.valid", r), iq_out_valid, v.e_vld);
        if (v.e_real != DC) chk($sformatf("row%0d.real", r), iq_out_real, v.e_real);
        if (v.e_imag != DC) chk($sformatf("row%0d.imag", r), iq_out_imag, v.e_imag);
    endtask

    initial begin
        int kl_a, kl_b, hold_a, hold_b;

        // CW key-up, hold at 21000, ramp-down and 10-clock hang
        tbl.push_back(mk(1, 0, 0, 0,     0,      0, 2, 0, 0, 0, 0, 0,     0,      0));
        tbl.push_back(mk(0, 1, 1, 0,  1000,   2000, 1, 1, 1, 0, 0, 0,     0,      0));
        tbl.push_back(mk(0, 1, 1, 0,  1000,   2000, 4, 2, 1, 1, 0, 1,     0,      0));
        tbl.push_back(mk(0, 1, 1, 0,  1000,   2000, 1, 2, 1, 1, 1, 1,     0,      0));
        tbl.push_back(mk(0, 1, 1, 0,  1000,   2000, 6, 2, 1, 1, 7, 1,  9000,      0));
        tbl.push_back(mk(0, 1, 1, 0,  1000,   2000, 1, 3, 1, 1, 7, 1, 12000,      0));
        tbl.push_back(mk(0, 1, 1, 0,  1000,   2000, 10, 3, 1, 1, 7, 1, 21000,     0));
        tbl.push_back(mk(0, 1, 0, 0,  1000,   2000, 1, 4, 1, 1, 7, 1, 21000,      0));
        tbl.push_back(mk(0, 1, 0, 0,  1000,   2000, 7, 4, 1, 1, 0, 1, 12000,      0));
        tbl.push_back(mk(0, 1, 0, 0,  1000,   2000, 1, 5, 1, 0, 0, 1,  9000,      0));
        tbl.push_back(mk(0, 1, 0, 0,  1000,   2000, 9, 5, 1, 0, 0, 1,     0,      0));
        tbl.push_back(mk(0, 1, 0, 0,  1000,   2000, 1, 0, 0, 0, 0, 1,     0,      0));
        // SSB scaling of (16384,-16384); ramp-down lands directly in idle
        tbl.push_back(mk(0, 0, 0, 1, 16384, -16384, 1, 1, 1, 0, 0, 1,     0,      0));
        tbl.push_back(mk(0, 0, 0, 1, 16384, -16384, 4, 2, 1, 1, 0, 1,     0,      0));
        tbl.push_back(mk(0, 0, 0, 1, 16384, -16384, 7, 2, 1, 1, 7, 1,  6144,  -6144));
        tbl.push_back(mk(0, 0, 0, 1, 16384, -16384, 1, 3, 1, 1, 7, 1,  8192,  -8192));
        tbl.push_back(mk(0, 0, 0, 1, 16384, -16384, 5, 3, 1, 1, 7, 1, 14336, -14336));
        tbl.push_back(mk(0, 0, 0, 0, 16384, -16384, 1, 4, 1, 1, 7, 1, 14336, -14336));
        tbl.push_back(mk(0, 0, 0, 0, 16384, -16384, 7, 4, 1, 1, 0, 1,  8192,  -8192));
        tbl.push_back(mk(0, 0, 0, 0, 16384, -16384, 1, 0, 0, 0, 0, 1,  6144,  -6144));
        // mode toggle in HOLD is ignored; reset mid ramp-down clears everything
        tbl.push_back(mk(0, 1, 1, 0,     5,      5, 1, 1, 1, 0, 0, 1,    DC,     DC));
        tbl.push_back(mk(0, 1, 1, 0,     5,      5, 4, 2, 1, 1, 0, 1,     0,      0));
        tbl.push_back(mk(0, 1, 1, 0,     5,      5, 8, 3, 1, 1, 7, 1, 12000,      0));
        tbl.push_back(mk(0, 0, 1, 0,     5,      5, 3, 3, 1, 1, 7, 1, 21000,      0));
        tbl.push_back(mk(0, 0, 0, 1,     5,      5, 1, 4, 1, 1, 7, 1, 21000,      0));
        tbl.push_back(mk(0, 0, 0, 1,     5,      5, 3, 4, 1, 1, 4, 1, 21000,      0));
        tbl.push_back(mk(1, 0, 0, 1,     5,      5, 1, 0, 0, 0, 0, 0,     0,      0));

        foreach (tbl[r]) begin
            drive(tbl[r].rst, tbl[r].mode, tbl[r].key, tbl[r].ptt, 1'b1, tbl[r].ir, tbl[r].ii);
            repeat (tbl[r].n) cycle();
            chk_row(r, tbl[r]);
        end

        // CW ramp reversal without a jump, both directions
        drive(1, 0, 0, 0, 1, 0, 0);
        repeat (2) cycle();
        drive(0, 1, 1, 0, 1, 100, 100);
        repeat (8) cycle();
        chk("rev.up.state", state, 2);
        chk("rev.up.addr", prof_addr, 3);
        cw_key = 1'b0;
        cycle();
        chk("rev.drop.state", state, 4);
        chk("rev.drop.addr", prof_addr, 3);
        cycle();
        chk("rev.down1.addr", prof_addr, 2);
        cycle();
        chk("rev.down2.addr", prof_addr, 1);
        cw_key = 1'b1;
        cycle();
        chk("rev.rekey.state", state, 2);
        chk("rev.rekey.addr", prof_addr, 1);
        cycle();
        chk("rev.up2.addr", prof_addr, 2);

        // randomized traffic against the model
        drive(1, 0, 0, 0, 0, 0, 0);
        repeat (2) cycle();
        kl_a = 0; kl_b = 0; hold_a = 0; hold_b = 0;
        for (int i = 0; i < 4000; i++) begin
            if (hold_a == 0) begin
                kl_a = $urandom_range(0, 1);
                hold_a = $urandom_range(1, 30);
            end
            if (hold_b == 0) begin
                kl_b = $urandom_range(0, 1);
                hold_b = $urandom_range(1, 30);
            end
            hold_a--;
            hold_b--;
            reset = ($urandom_range(0, 499) == 0);
            if ($urandom_range(0, 19) == 0) cw_mode = ~cw_mode;
            cw_key = kl_a[0];
            ptt_req = kl_b[0];
            iq_in_valid = ($urandom_range(0, 3) != 0);
            iq_in_real = IQW'(int'($urandom_range(0, 65535)) - 32768);
            iq_in_imag = IQW'(int'($urandom_range(0, 65535)) - 32768);
            cycle();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
